// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   WORD_SIZE          : width of one instruction word on the fetch bus
//   DEFAULT_NOP_WORD   : word presented to the EU while the queue is empty
//   DEFAULT_RESET_ADDR : byte address of the first fetch after reset
//   fetch_state_t      : fetch FSM encoding (IDLE=0, REQ=1, DROP=2)
package instr_prefetch_queue_pkg;

   localparam int WORD_SIZE = 16;

   localparam logic [WORD_SIZE-1:0] DEFAULT_NOP_WORD   = 16'h0900;
   localparam logic [19:0]          DEFAULT_RESET_ADDR = 20'hFFFF0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no request on the bus
      ST_REQ  = 2'd1,   // request outstanding, data will be queued
      ST_DROP = 2'd2    // request outstanding, data will be discarded
   } fetch_state_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Memory fetch bus between the prefetch queue (master) and memory (slave).
//   mem_req   : master -> slave, request valid
//   mem_addr  : master -> slave, byte address of the requested word (bit0 = 0)
//   mem_ack   : slave -> master, mem_rdata valid and request complete
//   mem_rdata : slave -> master, fetched word
//
// Handshake: the master raises mem_req with a stable mem_addr and holds both
// until the cycle in which mem_ack is high; that cycle completes the transfer
// and carries the data. There is never more than one request outstanding and
// a request cannot be withdrawn once raised. mem_ack while mem_req is low has
// no meaning and is ignored by the master.
interface instr_prefetch_queue_if
   import instr_prefetch_queue_pkg::*;
#(
   parameter int ADDR_W = 20
);

   logic                 mem_req;
   logic [ADDR_W-1:0]    mem_addr;
   logic                 mem_ack;
   logic [WORD_SIZE-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/instr_prefetch_queue_prefetch_fifo.sv
// Circular word storage for the prefetch queue.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : empty the queue and rewind both pointers (wins over push/pop)
//   push       : write wdata at the tail
//   pop        : drop the head word (caller only pops when non-empty)
//   wdata      : word to push
//   head       : head word, or NOP_WORD when empty
//   count      : number of words held
//   not_empty  : count != 0
module prefetch_fifo
   import instr_prefetch_queue_pkg::*;
#(
   parameter int                   DEPTH    = 3,
   parameter logic [WORD_SIZE-1:0] NOP_WORD = DEFAULT_NOP_WORD
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WORD_SIZE-1:0]           wdata,
   output logic [WORD_SIZE-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           not_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WORD_SIZE-1:0] storage [DEPTH];
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         // Push and pop together leave the count unchanged.
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Data storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (push && !clear) storage[wr_ptr] <= wdata;
   end

   assign not_empty = (count != '0);
   assign head      = not_empty ? storage[rd_ptr] : NOP_WORD;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue sitting between the memory bus and the EU.
// Fetches 16-bit words ahead of execution, buffers up to DEPTH of them and
// hands the head word to the EU; flush redirects fetching after a jump.
//   clk, reset        : clock, asynchronous active-high reset
//   mem               : fetch bus (master side), see instr_prefetch_queue_if
//   flush, flush_addr : discard queue and restart fetching at flush_addr
//   instruction       : head word, NOP_WORD when empty
//   instruction_ready : queue holds at least one word
//   eu_request        : EU consumes the head word (ignored when empty)
//   queue_count       : words currently held
//   fetch_state       : current fetch FSM state (debug visibility)
module instr_prefetch_queue
   import instr_prefetch_queue_pkg::*;
#(
   parameter int                   DEPTH      = 3,
   parameter int                   ADDR_W     = 20,
   parameter logic [ADDR_W-1:0]    RESET_ADDR = ADDR_W'(DEFAULT_RESET_ADDR),
   parameter logic [WORD_SIZE-1:0] NOP_WORD   = DEFAULT_NOP_WORD
)(
   input  logic                        clk,
   input  logic                        reset,
   instr_prefetch_queue_if.master      mem,
   input  logic                        flush,
   input  logic [ADDR_W-1:0]           flush_addr,
   output logic [WORD_SIZE-1:0]        instruction,
   output logic                        instruction_ready,
   input  logic                        eu_request,
   output logic [$clog2(DEPTH+1)-1:0]  queue_count,
   output fetch_state_t                fetch_state
);

   localparam int CW = $clog2(DEPTH+1);

   fetch_state_t      state;
   fetch_state_t      state_nx;
   logic [ADDR_W-1:0] fetch_ptr;     // next word to fetch (address of REQ)
   logic [ADDR_W-1:0] drop_addr;     // address of the in-flight discarded cycle
   logic [ADDR_W-1:0] flush_target;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_after_pop;
   logic              not_empty;
   logic              pop;
   logic              push;
   logic              unused_flush_lsb;

   assign flush_target     = {flush_addr[ADDR_W-1:1], 1'b0};
   assign unused_flush_lsb = flush_addr[0];

   // Flush takes priority: it suppresses both the pop and the push.
   assign pop             = eu_request && not_empty && !flush;
   assign push            = (state == ST_REQ) && mem.mem_ack && !flush;
   assign count_after_pop = count - CW'(pop);

   // A request is only issued when a slot is still free after this cycle's
   // pop (and push), so the word it returns always has room: the slot is
   // reserved at issue time.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (flush || (count_after_pop < CW'(DEPTH))) state_nx = ST_REQ;
         end
         ST_REQ: begin
            if (flush) begin
               // A bus cycle in flight must run to completion; its data is
               // dropped. If it completes right now, restart immediately.
               state_nx = mem.mem_ack ? ST_REQ : ST_DROP;
            end else if (mem.mem_ack) begin
               state_nx = (count_after_pop < CW'(DEPTH-1)) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DROP: begin
            // A flush here only retargets fetch_ptr; the FSM keeps draining.
            if (mem.mem_ack && !flush) state_nx = ST_REQ;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         fetch_ptr <= RESET_ADDR;
         drop_addr <= RESET_ADDR;
      end else begin
         state <= state_nx;
         if (flush)     fetch_ptr <= flush_target;
         else if (push) fetch_ptr <= fetch_ptr + ADDR_W'(2);
         if (state == ST_REQ && state_nx == ST_DROP) drop_addr <= fetch_ptr;
      end
   end

   // In DROP the bus still shows the old address while fetch_ptr already
   // holds the redirect target.
   assign mem.mem_req  = (state != ST_IDLE);
   assign mem.mem_addr = (state == ST_DROP) ? drop_addr : fetch_ptr;
   assign fetch_state  = state;

   prefetch_fifo #(
      .DEPTH    (DEPTH),
      .NOP_WORD (NOP_WORD)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (push),
      .pop       (pop),
      .wdata     (mem.mem_rdata),
      .head      (instruction),
      .count     (count),
      .not_empty (not_empty)
   );

   assign instruction_ready = not_empty;
   assign queue_count       = count;

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Bus-interface-side instruction prefetch queue, directly upstream of the EU pipeline.
- Fetches 16-bit instruction words from memory over a req/ack handshake and buffers up to DEPTH words (the 8086 6-byte queue at default).
- Presents the head word to the EU as instruction/instruction_ready and pops on eu_request.
- Supports a flush/redirect for jumps and reset-vector start.

Parameters:
- DEPTH, 3, queue capacity in 16-bit words (2..8).
- ADDR_W, 20, physical byte-address width.
- RESET_ADDR, 20'hFFFF0, first fetch byte address after reset.
- NOP_WORD, 16'h0900, word driven on instruction when the queue is empty.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
- mem_req  output  1  fetch request; held until mem_ack.
- mem_addr  output  ADDR_W  byte address of requested word; bit0 always 0.
- mem_ack  input  1  mem_rdata valid this cycle; completes the request.
- mem_rdata  input  16  fetched word.
- flush  input  1  discard queue, redirect fetch.
- flush_addr  input  ADDR_W  new fetch address; bit0 ignored (forced 0).
- instruction  output  16  head word; NOP_WORD when empty.
- instruction_ready  output  1  queue non-empty.
- eu_request  input  1  pop head when instruction_ready=1.
- queue_count  output  clog2(DEPTH+1)  words currently held.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=RESET_ADDR, instruction_ready=0, instruction=NOP_WORD, queue_count=0.
  - FSM=IDLE, read/write pointers=0.
- Storage:
  - Circular buffer of DEPTH words; rd_ptr and wr_ptr wrap at DEPTH-1 back to 0.
  - instruction is combinational from the head entry, or NOP_WORD when count=0.
  - instruction_ready = (count != 0).
- Pop:
  - A pop occurs when eu_request=1 and instruction_ready=1.
  - eu_request while empty is ignored; nothing changes.
- Push:
  - Occurs on mem_ack in state REQ.
  - mem_rdata is written at wr_ptr.
  - Latency: ack in cycle N gives instruction_ready=1 and instruction=word in cycle N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - At count=DEPTH this is legal because a slot was reserved at issue.
- FSM states:
  - IDLE:
    - If count + pop_adjusted < DEPTH (a free slot exists after this cycle's pop), go to REQ and assert mem_req with mem_addr = fetch_ptr.
    - Otherwise stay in IDLE.
  - REQ:
    - mem_req=1; mem_addr stable.
    - On mem_ack: push, fetch_ptr += 2 (wraps mod 2^ADDR_W).
    - Then go back-to-back to REQ if a slot remains after the push and pop; otherwise go to IDLE (mem_req=0).
  - DROP:
    - Entered when flush arrives while in REQ without ack.
    - mem_req stays 1 and mem_addr stays at the old address; a bus cycle cannot be aborted.
    - On mem_ack the data is discarded and the FSM moves to REQ at fetch_ptr (the flush address).
- Flush:
  - Priority over push and pop in the same cycle.
  - Sets count=0, rd_ptr=wr_ptr=0, instruction_ready=0 next cycle, fetch_ptr={flush_addr[ADDR_W-1:1],1'b0}.
  - From IDLE: next state REQ.
  - From REQ with mem_ack in the same cycle: data dropped, next state REQ at the new address.
  - From REQ without ack: DROP.
  - From DROP: fetch_ptr is updated; the FSM stays in DROP.
- Never more than one outstanding request.
- Queue never overflows: a request is issued only if count + 1 ≤ DEPTH after the pop.
- Reset mid-request: all state returns to reset values immediately. A late mem_ack after reset is ignored because the FSM is in IDLE.
- First cycle after reset release: IDLE → REQ at RESET_ADDR.

Decomposition:
- Shared package holds:
  - WORD_SIZE=16 and NOP_WORD.
  - Fetch FSM state encoding (IDLE=2'd0, REQ=2'd1, DROP=2'd2).
  - The default RESET_ADDR.
- One sub-module: prefetch_fifo.
  - Circular storage, pointers, count, head mux.
  - Push/pop/clear inputs.
- The fetch FSM and address counter stay in the top module.

Test Plan:
1. Reset release, memory acks each request after 1 wait cycle with words 16'h8B05, 16'h0107, 16'h2A3C → mem_addr sequence FFFF0, FFFF2, FFFF4; instruction_ready rises the cycle after the first ack; instruction=16'h8B05; with eu_request=0 the queue fills to 3 and mem_req drops to 0 with mem_addr=FFFF6 pending.
2. Full queue, then eu_request=1 for one cycle → pop 8B05; head becomes 0107; mem_req reasserts at FFFF6; queue_count returns to 3 after the ack.
3. Queue at 2, eu_request=1 in the same cycle as mem_ack → queue_count stays 2; head advances; order preserved.
4. flush with flush_addr=20'h01235 while REQ is outstanding with no ack → DROP; mem_req held at the old address; acked data discarded; next mem_addr=01234; instruction_ready=0 until the new word arrives.
5. eu_request=1 while empty → instruction=16'h0900, count stays 0, no pointer change.
6. reset asserted mid-REQ, then mem_ack pulsed while in reset and again after release → no push; mem_addr=FFFF0 on the first post-reset request.
